complex_mul_pipe: RTL and testbench
===================================

Name: complex_mul_pipe

Overview:
- Pipelined, parametrised fixed-point complex multiplier for the FFT butterfly and twiddle datapath; generalises the existing combinational 32-bit complex multiply.
- Operands are packed {real, imag} in two's-complement Q(DW-FRAC).FRAC format.
- Adds valid/ready flow control, an optional conjugate of operand b, selectable rounding, saturation with an overflow flag, and a saturating overflow-event counter.

Parameters:
- DW, 16, width of each real/imag component.
- FRAC, 12, number of fractional bits; 1.0 = 2^FRAC = 0x1000.
- ROUND, 1, 0 = truncate (floor), 1 = round-half-up.
- SAT, 1, 1 = saturate on overflow, 0 = wrap (keep low DW bits).
- CNTW, 16, width of the overflow-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept an input this cycle.
- a  in  2*DW  operand a, {re[2*DW-1:DW], im[DW-1:0]}.
- b  in  2*DW  operand b, same packing.
- conj_b  in  1  sampled with the operands; 1 multiplies by conj(b).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out  out  2*DW  product, {re, im}.
- ovf  out  1  qualified by out_valid; re or im overflowed.
- ovf_cnt  out  CNTW  count of accepted results with ovf=1; saturates at all-ones.
- ovf_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits = 0, out = 0, ovf = 0, ovf_cnt = 0. in_ready = 1 on the first edge after reset deasserts. Reset mid-flight discards all in-flight data with no residual out_valid.
- Pipeline:
  - S1 registers a, b and conj_b.
  - S2 registers the four signed 2*DW-bit products: ar*br, ai*bi, ar*bi, ai*br.
  - S3 forms sums, rounds, saturates and registers out, ovf and out_valid.
- Latency is 3 cycles from the accepting edge to out_valid with no stall. Throughput is 1 per cycle.
- Flow control:
  - Global stall: adv = !out_valid | out_ready.
  - in_ready = adv. An input is accepted on a clock edge when in_valid & in_ready.
  - All stages shift only when adv = 1, so no bubble collapse is required.
  - While stalled, out, ovf and out_valid hold stable.
  - Bubbles propagate as valid = 0. Data registers may hold stale values.
- Arithmetic, with sums held at 2*DW+1 bits signed:
  - conj_b = 0: re = ar*br - ai*bi; im = ar*bi + ai*br.
  - conj_b = 1: re = ar*br + ai*bi; im = ai*br - ar*bi.
- Scaling: with ROUND = 1, add 2^(FRAC-1) before an arithmetic right shift by FRAC. With ROUND = 0, shift only (floor).
- Range check: the result is in range if it lies within [-2^(DW-1), 2^(DW-1)-1].
  - Out of range with SAT = 1: clamp to 0x7FFF or 0x8000 (DW = 16) and set that component's overflow.
  - Out of range with SAT = 0: take the low DW bits and still set overflow.
  - ovf = re_ovf | im_ovf.
- ovf_cnt increments on each out_valid & out_ready & ovf, and holds at max.
  - If ovf_clr coincides with an increment, clear wins and the counter = 0.
- in_valid with in_ready = 0 must be held by the source. The block samples nothing while stalled.

Decomposition:
- A shared package fft_pkg holds:
  - the DW and FRAC defaults;
  - the constant ONE = 2^FRAC;
  - helper functions pack_cplx / re_of / im_of;
  - the function sat_round(sum, FRAC, ROUND, SAT) returning {ovf, value}.
- One natural sub-module: cplx_round_sat, the combinational S3 round/saturate for one component, instantiated twice (re, im).

Test Plan:
- Basic product: a = 0x1000_1000, b = 0x1000_1000 (1+j times 1+j) -> out = 0x0000_2000, ovf = 0, out_valid exactly 3 cycles after acceptance.
- Signed operands, back-to-back:
  - a = 0xF000_1000, b = 0xE000_F000 -> 0x3000_F000.
  - Next cycle a = 0x1800_F800, b = 0x1000_1000 -> 0x2000_1000.
  - Results appear on consecutive cycles.
- Conjugate: a = 0x1000_1000, b = 0x1000_1000, conj_b = 1 -> 0x2000_0000.
- Rounding: a = 0x0001_0000, b = 0x0800_0000 -> ROUND = 1 gives out re = 0x0001; ROUND = 0 gives re = 0x0000.
- Saturation and counter:
  - a = 0x4000_0000, b = 0x4000_0000 -> 0x7FFF_0000, ovf = 1.
  - b = 0xC000_0000 -> 0x8000_0000, ovf = 1.
  - ovf_cnt = 2; ovf_clr -> 0.
- Backpressure and reset:
  - Stream 6 inputs with out_ready low for 4 cycles mid-stream -> in_ready = 0 during the stall, out held stable, all 6 results in order with none lost or duplicated.
  - Assert rst with 3 in flight -> out_valid = 0 immediately, no stale results after release.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT butterfly / twiddle datapath.
//   DW_DEF, FRAC_DEF : default component width and fractional bits (Q4.12)
//   ONE              : fixed-point 1.0 at the default format
//   pack_cplx/re_of/im_of : {re, im} packing helpers at the default width
//   sat_round        : scale a wide sum by 2^-frac with optional rounding,
//                      range-check against dw bits, clamp or wrap; returns
//                      {ovf, value[63:0]} (value is valid in its low dw bits)
package fft_pkg;

  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = 12;
  localparam int ONE      = 1 << FRAC_DEF;

  function automatic logic [2*DW_DEF-1:0] pack_cplx(input logic [DW_DEF-1:0] re,
                                                     input logic [DW_DEF-1:0] im);
    return {re, im};
  endfunction

  function automatic logic [DW_DEF-1:0] re_of(input logic [2*DW_DEF-1:0] c);
    return c[2*DW_DEF-1:DW_DEF];
  endfunction

  function automatic logic [DW_DEF-1:0] im_of(input logic [2*DW_DEF-1:0] c);
    return c[DW_DEF-1:0];
  endfunction

  // The sum is carried at 64 bits, which covers component widths up to 31.
  // Floor semantics come from the arithmetic shift; round-half-up is the
  // same shift after adding half an LSB of the result.
  function automatic logic [64:0] sat_round(input logic signed [63:0] sum,
                                            input int                 frac,
                                            input bit                 round,
                                            input bit                 sat,
                                            input int                 dw);
    logic signed [63:0] biased;
    logic signed [63:0] shifted;
    logic signed [63:0] vmax;
    logic signed [63:0] vmin;
    logic               ovf;
    logic [63:0]        val;
    biased = sum;
    if (round && frac > 0) biased = sum + (64'sd1 <<< (frac - 1));
    shifted = biased >>> frac;
    vmax    = (64'sd1 <<< (dw - 1)) - 64'sd1;
    vmin    = -(64'sd1 <<< (dw - 1));
    ovf     = 1'b0;
    val     = shifted;
    if (shifted > vmax) begin
      ovf = 1'b1;
      val = sat ? vmax : shifted;
    end else if (shifted < vmin) begin
      ovf = 1'b1;
      val = sat ? vmin : shifted;
    end
    return {ovf, val};
  endfunction

endpackage

// File: rtl/cplx_round_sat.sv
// Combinational scale / round / saturate for one complex component.
//   sum   : signed 2*DW+1-bit sum of two products (Q at 2*FRAC fraction bits)
//   value : DW-bit result in Q(DW-FRAC).FRAC
//   ovf   : the scaled sum did not fit in DW bits (clamped or wrapped)
module cplx_round_sat
  import fft_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic signed [2*DW:0] sum,
  output logic [DW-1:0]        value,
  output logic                 ovf
);

  logic signed [63:0] sum_ext;
  logic [64:0]        res;
  logic               unused_hi;

  assign sum_ext   = {{(63 - 2*DW){sum[2*DW]}}, sum};
  assign res       = sat_round(sum_ext, FRAC, ROUND != 0, SAT != 0, DW);
  assign value     = res[DW-1:0];
  assign ovf       = res[64];
  // Upper bits are either sign copies or wrapped-away bits; deliberately dropped.
  assign unused_hi = ^res[63:DW];

endmodule

// File: rtl/complex_mul_pipe.sv
// Three-stage pipelined fixed-point complex multiplier with valid/ready.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake; a, b packed {re, im}; conj_b
//                         selects a * conj(b)
//   out_valid/out_ready : output handshake; out packed {re, im}
//   ovf                 : re or im overflowed (qualified by out_valid)
//   ovf_cnt / ovf_clr   : saturating count of accepted overflowed results,
//                         synchronous clear (clear beats increment)
// Stages: S1 operands, S2 four partial products, S3 sum/round/saturate.
// One global advance signal moves every stage together, so a stall freezes
// the whole pipe and no bubble collapsing is needed.
module complex_mul_pipe
  import fft_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ROUND = 1,
  parameter int SAT   = 1,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   a,
  input  logic [2*DW-1:0]   b,
  input  logic              conj_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out,
  output logic              ovf,
  output logic [CNTW-1:0]   ovf_cnt,
  input  logic              ovf_clr
);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1 operands
  logic            s1_valid;
  logic [2*DW-1:0] s1_a;
  logic [2*DW-1:0] s1_b;
  logic            s1_conj;

  // S2 products
  logic                   s2_valid;
  logic                   s2_conj;
  logic signed [2*DW-1:0] s2_rr;  // ar*br
  logic signed [2*DW-1:0] s2_ii;  // ai*bi
  logic signed [2*DW-1:0] s2_ri;  // ar*bi
  logic signed [2*DW-1:0] s2_ir;  // ai*br

  logic signed [DW-1:0] ar, ai, br, bi;
  assign ar = s1_a[2*DW-1:DW];
  assign ai = s1_a[DW-1:0];
  assign br = s1_b[2*DW-1:DW];
  assign bi = s1_b[DW-1:0];

  // S3 combinational sums
  logic signed [2*DW:0] re_sum;
  logic signed [2*DW:0] im_sum;
  logic [DW-1:0]        re_val, im_val;
  logic                 re_ovf, im_ovf;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    re_sum = '0;
    im_sum = '0;
    if (s2_conj) begin
      re_sum = (2*DW+1)'(s2_rr) + (2*DW+1)'(s2_ii);
      im_sum = (2*DW+1)'(s2_ir) - (2*DW+1)'(s2_ri);
    end else begin
      re_sum = (2*DW+1)'(s2_rr) - (2*DW+1)'(s2_ii);
      im_sum = (2*DW+1)'(s2_ri) + (2*DW+1)'(s2_ir);
    end
  end

  cplx_round_sat #(.DW(DW), .FRAC(FRAC), .ROUND(ROUND), .SAT(SAT)) u_re (
    .sum   (re_sum),
    .value (re_val),
    .ovf   (re_ovf)
  );

  cplx_round_sat #(.DW(DW), .FRAC(FRAC), .ROUND(ROUND), .SAT(SAT)) u_im (
    .sum   (im_sum),
    .value (im_val),
    .ovf   (im_ovf)
  );

  // Control and visible outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out       <= {re_val, im_val};
      ovf       <= re_ovf || im_ovf;
    end
  end

  // NOTE: internal data registers are not reset; the valid bits alone say
  // whether they hold anything, and keeping them out of the reset block
  // avoids reset fan-out and a reset-gated enable on wide datapaths.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_a    <= a;
      s1_b    <= b;
      s1_conj <= conj_b;
      s2_conj <= s1_conj;
      s2_rr   <= (2*DW)'(ar) * (2*DW)'(br);
      s2_ii   <= (2*DW)'(ai) * (2*DW)'(bi);
      s2_ri   <= (2*DW)'(ar) * (2*DW)'(bi);
      s2_ir   <= (2*DW)'(ai) * (2*DW)'(br);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && ovf && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Directed bench for complex_mul_pipe. A second instance with truncation,
// wrap-on-overflow and a 2-bit counter shares all inputs so the alternate
// scaling modes and counter saturation are observed on the same stimulus.
module tb_complex_mul_pipe;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, alt_in_ready;
  logic [31:0] a, b;
  logic        conj_b;
  logic        out_valid, alt_out_valid;
  logic        out_ready;
  logic [31:0] out, alt_out;
  logic        ovf, alt_ovf;
  logic [15:0] ovf_cnt;
  logic [1:0]  alt_ovf_cnt;
  logic        ovf_clr;

  always #5 clk = ~clk;

  complex_mul_pipe #(.DW(16), .FRAC(12), .ROUND(1), .SAT(1), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .conj_b(conj_b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  complex_mul_pipe #(.DW(16), .FRAC(12), .ROUND(0), .SAT(0), .CNTW(2)) dut_alt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(alt_in_ready),
    .a(a), .b(b), .conj_b(conj_b), .out_valid(alt_out_valid), .out_ready(out_ready),
    .out(alt_out), .ovf(alt_ovf), .ovf_cnt(alt_ovf_cnt), .ovf_clr(ovf_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        conj;
    logic [31:0] exp_out;
    logic        exp_ovf;
    logic [31:0] exp_alt;
    logic        exp_alt_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    conj_b   = v.conj;
  endtask

  // One isolated transaction: accepting edge, then two more edges until the
  // result registers; out_valid must be low in between. Returns at the
  // negedge where the result is visible (consumed on the following edge).
  task automatic run_one(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " valid after accept+0"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, " valid after accept+1"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, " valid after accept+2"}, out_valid, 1'b1);
    check({tag, " out"}, out, v.exp_out);
    check({tag, " ovf"}, ovf, v.exp_ovf);
    check({tag, " alt valid"}, alt_out_valid, 1'b1);
    check({tag, " alt out"}, alt_out, v.exp_alt);
    check({tag, " alt ovf"}, alt_ovf, v.exp_alt_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_exp[6];
    logic [31:0] held_out;
    logic        prev_stall;
    int          sent, got, cyc;

    //              a             b             cj  main out      ov  alt out       ov
    vecs[0]  = '{32'h1000_1000, 32'h1000_1000, 0, 32'h0000_2000, 0, 32'h0000_2000, 0};
    vecs[1]  = '{32'hF000_1000, 32'hE000_F000, 0, 32'h3000_F000, 0, 32'h3000_F000, 0};
    vecs[2]  = '{32'h1800_F800, 32'h1000_1000, 0, 32'h2000_1000, 0, 32'h2000_1000, 0};
    vecs[3]  = '{32'h1000_1000, 32'h1000_1000, 1, 32'h2000_0000, 0, 32'h2000_0000, 0};
    vecs[4]  = '{32'h0001_0000, 32'h0800_0000, 0, 32'h0001_0000, 0, 32'h0000_0000, 0};
    vecs[5]  = '{32'hFFFF_0000, 32'h0800_0000, 0, 32'h0000_0000, 0, 32'hFFFF_0000, 0};
    vecs[6]  = '{32'h4000_0000, 32'h4000_0000, 0, 32'h7FFF_0000, 1, 32'h0000_0000, 1};
    vecs[7]  = '{32'h4000_0000, 32'hC000_0000, 0, 32'h8000_0000, 1, 32'h0000_0000, 1};
    vecs[8]  = '{32'h4000_4000, 32'h4000_4000, 0, 32'h0000_7FFF, 1, 32'h0000_0000, 1};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 0, 32'h7FFF_0000, 1, 32'h0000_0000, 1};
    vecs[10] = '{32'h2000_0000, 32'h0000_1000, 0, 32'h0000_2000, 0, 32'h0000_2000, 0};
    vecs[11] = '{32'h7FFF_0000, 32'h1000_0000, 0, 32'h7FFF_0000, 0, 32'h7FFF_0000, 0};
    vecs[12] = '{32'h8000_0000, 32'h1000_0000, 0, 32'h8000_0000, 0, 32'h8000_0000, 0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; conj_b = 1'b0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out", out, 32'h0);
    check("reset ovf", ovf, 1'b0);
    check("reset ovf_cnt", ovf_cnt, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", in_ready, 1'b1);

    // Table: each vector alone, latency and both scaling modes.
    for (int i = 0; i < 13; i++) run_one(vecs[i], $sformatf("vec%0d", i));
    @(negedge clk);
    check("ovf_cnt after table", ovf_cnt, 16'd4);
    check("alt ovf_cnt saturates", alt_ovf_cnt, 2'd3);

    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cnt cleared", ovf_cnt, 16'd0);
    check("alt ovf_cnt cleared", alt_ovf_cnt, 2'd0);

    // Two saturating results count to 2.
    run_one(vecs[6], "sat pos");
    run_one(vecs[7], "sat neg");
    @(negedge clk);
    check("ovf_cnt two events", ovf_cnt, 16'd2);

    // Clear on the same edge as an increment: clear wins.
    run_one(vecs[8], "sat im");
    check("ovf_cnt before coincident clear", ovf_cnt, 16'd2);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cnt clear beats increment", ovf_cnt, 16'd0);
    check("alt ovf_cnt clear beats increment", alt_ovf_cnt, 2'd0);
    run_one(vecs[9], "sat both");
    @(negedge clk);
    check("ovf_cnt after clear resumes", ovf_cnt, 16'd1);

    // Back-to-back signed operands: results on consecutive cycles.
    @(negedge clk); drive(vecs[1]);
    @(negedge clk); drive(vecs[2]);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("b2b first valid", out_valid, 1'b1);
    check("b2b first out", out, vecs[1].exp_out);
    @(negedge clk);
    check("b2b second valid", out_valid, 1'b1);
    check("b2b second out", out, vecs[2].exp_out);
    @(negedge clk);
    check("b2b drained", out_valid, 1'b0);

    // Backpressure: six inputs k + j times 1.0, out_ready low 4 cycles.
    for (int k = 0; k < 6; k++) bp_exp[k] = {16'((k + 1) * ONE), 16'h1000};
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; held_out = '0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = (sent < 6);
      a         = {16'((sent + 1) * ONE), 16'h1000};
      b         = 32'h1000_0000;
      conj_b    = 1'b0;
      #1;
      if (prev_stall) begin
        check($sformatf("bp held valid c%0d", cyc), out_valid, 1'b1);
        check($sformatf("bp held out c%0d", cyc), out, held_out);
      end
      if (out_valid && !out_ready)
        check($sformatf("bp in_ready low c%0d", cyc), in_ready, 1'b0);
      if (out_valid && out_ready) begin
        check($sformatf("bp result %0d", got), out, bp_exp[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      held_out   = out;
      cyc++;
    end
    check("bp results received", got, 6);
    check("bp inputs accepted", sent, 6);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp no duplicate %0d", k), out_valid, 1'b0);
    end

    // Reset with three transactions in flight.
    @(negedge clk); drive(vecs[0]);
    @(negedge clk); drive(vecs[1]);
    @(negedge clk); drive(vecs[2]);
    @(negedge clk); in_valid = 1'b0;
    check("in-flight valid before reset", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset out", out, 32'h0);
    check("async reset ovf_cnt", ovf_cnt, 16'h0);
    check("async reset alt out_valid", alt_out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("no stale result %0d", k), out_valid, 1'b0);
    end
    run_one(vecs[3], "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
